// File: rtl/battleship_pkg.sv
// Shared battleship definitions: grid defaults,
// evaluator state encoding and cell indexing.
package battleship_pkg;

  localparam int DEF_ROWS      = 8;
  localparam int DEF_COLS      = 8;
  localparam int DEF_MAX_TURNS = 40;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY,
    ST_EVAL,
    ST_OVER
  } eval_state_t;

  function automatic int unsigned cell_index(
    input int unsigned row,
    input int unsigned col,
    input int unsigned ncols
  );
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/battleship_shot_evaluator_if.sv
// Shot request / result bundle between the game
// FSM (master) and the shot evaluator (slave).
interface battleship_shot_evaluator_if
  import battleship_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HW = $clog2(ROWS * COLS + 1);

  logic          shot_valid;
  logic          shot_ready;
  logic [RW-1:0] shot_row;
  logic [CW-1:0] shot_col;
  logic          result_valid;
  logic          hit;
  logic          repeat_shot;
  logic          invalid_shot;
  logic          all_ships_sunk;
  logic          turns_exhausted;
  logic [7:0]    turns_left;
  logic [HW-1:0] hits_remaining;

  modport master (
    output shot_valid,
    output shot_row,
    output shot_col,
    input  shot_ready,
    input  result_valid,
    input  hit,
    input  repeat_shot,
    input  invalid_shot,
    input  all_ships_sunk,
    input  turns_exhausted,
    input  turns_left,
    input  hits_remaining
  );

  modport slave (
    input  shot_valid,
    input  shot_row,
    input  shot_col,
    output shot_ready,
    output result_valid,
    output hit,
    output repeat_shot,
    output invalid_shot,
    output all_ships_sunk,
    output turns_exhausted,
    output turns_left,
    output hits_remaining
  );

endinterface

// File: rtl/battleship_shot_mask.sv
// Shot-history bitmap: synchronous clear,
// single-bit set and one read port.
module battleship_shot_mask #(
  parameter int CELLS = 64,
  parameter int IW    = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_set,
  input  logic [IW-1:0] i_set_idx,
  input  logic [IW-1:0] i_rd_idx,
  output logic          o_rd_bit
);

  logic [CELLS-1:0] r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (i_clr) begin
      r_mask <= '0;
    end else if (i_set) begin
      for (int i = 0; i < CELLS; i++) begin
        if (i_set_idx == IW'(i)) begin
          r_mask[i] <= 1'b1;
        end
      end
    end
  end

  assign o_rd_bit = r_mask[i_rd_idx];

endmodule

// File: rtl/battleship_shot_evaluator.sv
// Holds one game's ship layout and shot history,
// and resolves each accepted shot into a result.
module battleship_shot_evaluator
  import battleship_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int MAX_TURNS = DEF_MAX_TURNS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_restart_pulse,
  input  logic [ROWS*COLS-1:0]   i_ship_map,
  battleship_shot_evaluator_if.slave shot_if
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HW = $clog2(CELLS + 1);

  eval_state_t r_state;
  eval_state_t w_next;

  logic [CELLS-1:0] r_map;
  logic [IW-1:0]    r_scan_idx;
  logic [HW-1:0]    r_hits;
  logic [7:0]       r_turns;
  logic             r_sunk;
  logic             r_exh;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic             r_rv;
  logic             r_hit;
  logic             r_rep;
  logic             r_inv;

  logic          w_in_range;
  logic [IW-1:0] w_cell_idx;
  logic          w_hist;
  logic          w_ship;
  logic          w_inv;
  logic          w_rep;
  logic          w_fresh;
  logic          w_scan_last;
  logic [HW-1:0] w_load_hits;
  logic [HW-1:0] w_hits_next;
  logic [7:0]    w_turns_next;
  logic          w_mask_set;

  assign w_in_range = (32'(r_row) < ROWS)
                   && (32'(r_col) < COLS);
  assign w_cell_idx = IW'(cell_index(
    32'(r_row), 32'(r_col), COLS));
  assign w_ship = r_map[w_cell_idx];

  // Out-of-range outranks repeat: history is only
  // meaningful for real cells.
  always_comb begin
    w_inv   = 1'b0;
    w_rep   = 1'b0;
    w_fresh = 1'b0;
    priority case (1'b1)
      !w_in_range: w_inv   = 1'b1;
      w_hist:      w_rep   = 1'b1;
      default:     w_fresh = 1'b1;
    endcase
  end

  assign w_hits_next =
    (w_fresh && w_ship && r_hits != '0)
      ? r_hits - HW'(1) : r_hits;
  assign w_turns_next =
    (w_fresh && r_turns != 8'd0)
      ? r_turns - 8'd1 : r_turns;

  assign w_scan_last = (r_scan_idx == IW'(CELLS - 1));
  assign w_load_hits = r_hits
    + (r_map[r_scan_idx] ? HW'(1) : HW'(0));

  assign w_mask_set = (r_state == ST_EVAL)
                   && w_fresh && !i_restart_pulse;

  battleship_shot_mask #(
    .CELLS (CELLS),
    .IW    (IW)
  ) u_mask (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (i_restart_pulse),
    .i_set     (w_mask_set),
    .i_set_idx (w_cell_idx),
    .i_rd_idx  (w_cell_idx),
    .o_rd_bit  (w_hist)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_restart_pulse) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_scan_last) begin
            w_next = (w_load_hits != '0)
                   ? ST_READY : ST_OVER;
          end
        end
        ST_READY: begin
          if (shot_if.shot_valid) w_next = ST_EVAL;
        end
        ST_EVAL: begin
          w_next = (w_hits_next == '0
                 || w_turns_next == 8'd0)
                 ? ST_OVER : ST_READY;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_map      <= '0;
      r_scan_idx <= '0;
      r_hits     <= '0;
      r_turns    <= 8'd0;
      r_sunk     <= 1'b0;
      r_exh      <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_rv       <= 1'b0;
      r_hit      <= 1'b0;
      r_rep      <= 1'b0;
      r_inv      <= 1'b0;
    end else if (i_restart_pulse) begin
      r_map      <= i_ship_map;
      r_scan_idx <= '0;
      r_hits     <= '0;
      r_turns    <= 8'(MAX_TURNS);
      r_sunk     <= 1'b0;
      r_exh      <= 1'b0;
      r_rv       <= 1'b0;
      r_hit      <= 1'b0;
      r_rep      <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_hits <= w_load_hits;
          if (w_scan_last) begin
            r_sunk <= (w_load_hits == '0);
          end else begin
            r_scan_idx <= r_scan_idx + IW'(1);
          end
        end
        ST_READY: begin
          if (shot_if.shot_valid) begin
            r_row <= shot_if.shot_row;
            r_col <= shot_if.shot_col;
          end
        end
        ST_EVAL: begin
          r_rv    <= 1'b1;
          r_inv   <= w_inv;
          r_rep   <= w_rep;
          r_hit   <= w_fresh && w_ship;
          r_hits  <= w_hits_next;
          r_turns <= w_turns_next;
          r_sunk  <= (w_hits_next == '0);
          r_exh   <= (w_turns_next == 8'd0);
        end
        default: ;
      endcase
    end
  end

  assign shot_if.shot_ready      = (r_state == ST_READY);
  assign shot_if.result_valid    = r_rv;
  assign shot_if.hit             = r_hit;
  assign shot_if.repeat_shot     = r_rep;
  assign shot_if.invalid_shot    = r_inv;
  assign shot_if.all_ships_sunk  = r_sunk;
  assign shot_if.turns_exhausted = r_exh;
  assign shot_if.turns_left      = r_turns;
  assign shot_if.hits_remaining  = r_hits;

endmodule

// File: tb/tb_battleship_shot_evaluator.sv
// Bench for battleship_shot_evaluator: three
// instances (8x8/40, 8x8/2, 6x8/40) share stimulus.
module tb_battleship_shot_evaluator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_pulse = 1'b0;
  logic [63:0] map = '0;
  logic        sv = 1'b0;
  logic [2:0]  row = '0;
  logic [2:0]  col = '0;
  int          sel = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  battleship_shot_evaluator_if #(.ROWS(8), .COLS(8)) if0 ();
  battleship_shot_evaluator_if #(.ROWS(8), .COLS(8)) if1 ();
  battleship_shot_evaluator_if #(.ROWS(6), .COLS(8)) if2 ();

  assign if0.shot_valid = sv && (sel == 0);
  assign if1.shot_valid = sv && (sel == 1);
  assign if2.shot_valid = sv && (sel == 2);
  assign if0.shot_row = row;
  assign if1.shot_row = row;
  assign if2.shot_row = row;
  assign if0.shot_col = col;
  assign if1.shot_col = col;
  assign if2.shot_col = col;

  battleship_shot_evaluator #(
    .ROWS(8), .COLS(8), .MAX_TURNS(40)
  ) d0 (
    .clk             (clk),
    .reset           (reset),
    .i_restart_pulse (rst_pulse && sel == 0),
    .i_ship_map      (map),
    .shot_if         (if0)
  );

  battleship_shot_evaluator #(
    .ROWS(8), .COLS(8), .MAX_TURNS(2)
  ) d1 (
    .clk             (clk),
    .reset           (reset),
    .i_restart_pulse (rst_pulse && sel == 1),
    .i_ship_map      (map),
    .shot_if         (if1)
  );

  battleship_shot_evaluator #(
    .ROWS(6), .COLS(8), .MAX_TURNS(40)
  ) d2 (
    .clk             (clk),
    .reset           (reset),
    .i_restart_pulse (rst_pulse && sel == 2),
    .i_ship_map      (map[47:0]),
    .shot_if         (if2)
  );

  logic       c_ready, c_rv, c_hit, c_rep, c_inv;
  logic       c_sunk, c_exh;
  logic [7:0] c_turns;
  logic [6:0] c_hits;

  always_comb begin
    c_ready = if0.shot_ready;
    c_rv    = if0.result_valid;
    c_hit   = if0.hit;
    c_rep   = if0.repeat_shot;
    c_inv   = if0.invalid_shot;
    c_sunk  = if0.all_ships_sunk;
    c_exh   = if0.turns_exhausted;
    c_turns = if0.turns_left;
    c_hits  = if0.hits_remaining;
    if (sel == 1) begin
      c_ready = if1.shot_ready;
      c_rv    = if1.result_valid;
      c_hit   = if1.hit;
      c_rep   = if1.repeat_shot;
      c_inv   = if1.invalid_shot;
      c_sunk  = if1.all_ships_sunk;
      c_exh   = if1.turns_exhausted;
      c_turns = if1.turns_left;
      c_hits  = if1.hits_remaining;
    end else if (sel == 2) begin
      c_ready = if2.shot_ready;
      c_rv    = if2.result_valid;
      c_hit   = if2.hit;
      c_rep   = if2.repeat_shot;
      c_inv   = if2.invalid_shot;
      c_sunk  = if2.all_ships_sunk;
      c_exh   = if2.turns_exhausted;
      c_turns = if2.turns_left;
      c_hits  = 7'(if2.hits_remaining);
    end
  end

  typedef struct {
    logic [19:0] v;
    int          acc;
  } sb_t;

  typedef struct {
    int          r;
    int          c;
    logic [19:0] v;
  } vec_t;

  sb_t  q[$];
  vec_t vt[15];

  function automatic logic [19:0] pk(
    input bit sunk, input bit exh, input bit hit,
    input bit rep, input bit inv,
    input logic [7:0] t, input logic [6:0] h
  );
    return {sunk, exh, hit, rep, inv, t, h};
  endfunction

  task automatic check(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (c_rv) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got rv=1 want 0");
      end else begin
        sb_t s;
        s = q.pop_front();
        check("result", pk(c_sunk, c_exh, c_hit,
              c_rep, c_inv, c_turns, c_hits), s.v);
        check("latency", cyc - s.acc, 1);
      end
    end
  end

  // mode 0: accept+score, 1: accept only, 2: refuse
  task automatic shoot(
    input int r, input int c,
    input logic [19:0] v, input int mode
  );
    bit  acc;
    sb_t s;
    acc = 1'b0;
    row = 3'(r);
    col = 3'(c);
    sv  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (c_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      s.v   = v;
      s.acc = cyc + 1;
      if (mode == 0) q.push_back(s);
      @(negedge clk);
    end
    sv = 1'b0;
    check("accept", acc, (mode != 2));
  endtask

  task automatic restart(
    input int s, input logic [63:0] m,
    input int exp_cnt, input bit exp_ready,
    input int exp_hits, input int exp_turns
  );
    int cnt;
    bit rv_seen;
    sel = s;
    map = m;
    rst_pulse = 1'b1;
    @(negedge clk);
    rst_pulse = 1'b0;
    cnt = 1;
    rv_seen = 1'b0;
    while (!(c_ready || c_sunk) && cnt < 200) begin
      if (c_rv) rv_seen = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check("load_cycles", cnt, exp_cnt);
    check("load_ready", c_ready, exp_ready);
    check("load_sunk", c_sunk, !exp_ready);
    check("load_exh", c_exh, 0);
    check("load_hits", c_hits, exp_hits);
    check("load_turns", c_turns, exp_turns);
    check("load_rv", rv_seen, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      shoot(vt[i].r, vt[i].c, vt[i].v, 0);
    end
  endtask

  localparam logic [63:0] MAP_A = 64'h8000_0000_0000_0201;
  localparam logic [63:0] MAP_B = 64'h0000_8000_0000_0001;

  initial begin
    vt[0]  = '{0, 0, pk(0, 0, 1, 0, 0, 39, 2)};
    vt[1]  = '{0, 0, pk(0, 0, 0, 1, 0, 39, 2)};
    vt[2]  = '{3, 4, pk(0, 0, 0, 0, 0, 38, 2)};
    vt[3]  = '{1, 1, pk(0, 0, 1, 0, 0, 37, 1)};
    vt[4]  = '{1, 1, pk(0, 0, 0, 1, 0, 37, 1)};
    vt[5]  = '{7, 7, pk(1, 0, 1, 0, 0, 36, 0)};
    vt[6]  = '{1, 1, pk(0, 0, 1, 0, 0, 39, 2)};
    vt[7]  = '{7, 7, pk(0, 0, 1, 0, 0, 38, 1)};
    vt[8]  = '{0, 0, pk(1, 0, 1, 0, 0, 37, 0)};
    vt[9]  = '{2, 2, pk(0, 0, 0, 0, 0, 1, 3)};
    vt[10] = '{2, 3, pk(0, 1, 0, 0, 0, 0, 3)};
    vt[11] = '{7, 0, pk(0, 0, 0, 0, 1, 40, 2)};
    vt[12] = '{6, 3, pk(0, 0, 0, 0, 1, 40, 2)};
    vt[13] = '{5, 7, pk(0, 0, 1, 0, 0, 39, 1)};
    vt[14] = '{0, 0, pk(1, 0, 1, 0, 0, 38, 0)};

    repeat (3) @(negedge clk);
    check("reset_state", pk(c_sunk, c_exh, c_hit,
          c_rep, c_inv, c_turns, c_hits), 0);
    check("reset_ready_rv", {c_ready, c_rv}, 0);
    reset = 1'b0;
    @(negedge clk);

    shoot(0, 0, 0, 2);

    restart(0, MAP_A, 65, 1, 3, 40);
    run_vecs(0, 5);
    shoot(0, 0, 0, 2);
    drain();

    restart(0, MAP_A, 65, 1, 3, 40);
    run_vecs(6, 8);
    shoot(2, 2, 0, 2);
    check("over_ready", c_ready, 0);
    drain();

    restart(1, MAP_A, 65, 1, 3, 2);
    run_vecs(9, 10);
    shoot(4, 4, 0, 2);
    drain();

    restart(0, MAP_A, 65, 1, 3, 40);
    shoot(0, 0, 0, 1);
    restart(0, MAP_A, 65, 1, 3, 40);
    run_vecs(0, 0);
    drain();

    restart(0, 64'h0, 65, 0, 0, 40);
    shoot(0, 0, 0, 2);
    drain();

    restart(2, MAP_B, 49, 1, 2, 40);
    run_vecs(11, 14);
    drain();

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/battleship_shot_evaluator.md
# battleship_shot_evaluator

Responder side of the shot interface driven by `battleship_fsm`. It holds the ship layout and shot history for one game. It accepts a shot coordinate and returns the hit/miss result with game-status flags (`all_ships_sunk`, `turns_exhausted`) that the game FSM consumes. The FSM's `restart_pulse` clears the board and starts loading a new layout.

## Interface
- `ROWS`, default 8: grid rows.
- `COLS`, default 8: grid columns.
- `MAX_TURNS`, default 40: shots allowed per game. Legal range is 1..255.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `restart_pulse`, in, 1: one-cycle request to start a new game. It latches `ship_map`.
- `ship_map`, in, ROWS*COLS: ship layout. Bit index is row*COLS+col; 1 = ship cell.
- `shot_valid`, in, 1: shot request.
- `shot_row`, in, $clog2(ROWS): target row.
- `shot_col`, in, $clog2(COLS): target column.
- `shot_ready`, out, 1: the block can accept a shot this cycle.
- `result_valid`, out, 1: one-cycle pulse; the result fields below are valid.
- `hit`, out, 1: the shot struck an unshot ship cell.
- `repeat_shot`, out, 1: the target cell had already been shot.
- `invalid_shot`, out, 1: the coordinate is out of range.
- `all_ships_sunk`, out, 1: level. No ship cells remain unhit.
- `turns_exhausted`, out, 1: level. `turns_left` is 0.
- `turns_left`, out, 8: remaining turns.
- `hits_remaining`, out, $clog2(ROWS*COLS+1): ship cells not yet hit.

## Operation
- States:
  - EMPTY: after reset, no layout loaded.
  - LOAD: scanning the layout.
  - READY: waiting for a shot.
  - EVAL: evaluating an accepted shot.
  - OVER: game finished.
- `shot_ready` is 1 only in READY. It is combinational from state.
- EMPTY -> LOAD on `restart_pulse`. No other input is honoured in EMPTY.
- On entry to LOAD:
  - latch `ship_map`;
  - clear the shot-history mask;
  - set `hits_remaining` = 0 and `turns_left` = MAX_TURNS;
  - clear both flags.
- LOAD scans one cell per cycle, indices 0..ROWS*COLS-1, adding 1 to `hits_remaining` per ship cell. It lasts exactly ROWS*COLS cycles.
- At the end of LOAD: go to READY if `hits_remaining` > 0. Otherwise set `all_ships_sunk` = 1 and go to OVER.
- READY -> EVAL when `shot_valid` && `shot_ready`. The coordinates are latched at that edge.
- EVAL takes one cycle. Resolve in this priority order:
  - row >= ROWS or col >= COLS: `invalid_shot` = 1. No turn is consumed and no state changes.
  - history bit already set: `repeat_shot` = 1, `hit` = 0. No turn is consumed.
  - otherwise:
    - set the history bit;
    - decrement `turns_left`;
    - if it is a ship cell, `hit` = 1 and decrement `hits_remaining`.
- EVAL -> OVER if the updated `hits_remaining` == 0 or `turns_left` == 0. Otherwise EVAL -> READY.
- A final shot that both sinks the last ship and uses the last turn sets both flags.
- OVER holds all outputs until `restart_pulse`, then goes to LOAD.
- `restart_pulse` in any state except EMPTY goes to LOAD.
  - This aborts any scan or evaluation in progress.
  - No `result_valid` is produced for an aborted evaluation.
- `restart_pulse` and `shot_valid` in the same cycle in READY: restart wins and the shot is dropped.
- Counters never wrap. Both decrements are guarded at 0.

## Timing
- Reset values:
  - state EMPTY;
  - `shot_ready`, `result_valid`, `hit`, `repeat_shot`, `invalid_shot` all 0;
  - `all_ships_sunk`, `turns_exhausted` both 0;
  - `turns_left` 0, `hits_remaining` 0;
  - history mask cleared.
- Shot latency, taking acceptance at edge N as cycle N:
  - cycle N+1: EVAL;
  - cycle N+2: `result_valid` = 1, with the result fields, flags and counters updated at the same edge.
  - The next acceptance can occur at the start of cycle N+2. Peak rate is one shot per 2 cycles.
- Result fields (`hit`, `repeat_shot`, `invalid_shot`) hold their values until the next result or restart. They are meaningful only while `result_valid` = 1.
- `restart_pulse` at edge M:
  - LOAD occupies cycles M+1 .. M+ROWS*COLS;
  - READY (or OVER) begins in cycle M+ROWS*COLS+1.
- `result_valid` deasserts on entry to LOAD.

## Structure
- Shared package `battleship_pkg` holds:
  - default ROWS, COLS, MAX_TURNS;
  - the evaluator state encoding;
  - the cell-index function (row*COLS+col), reused by display logic.
- Sub-module `battleship_shot_mask` holds the ROWS*COLS shot-history register, with a synchronous clear, a single-bit set, and a read port.

## Test plan
- Layout with ship cells {0, 9, 63}, restart: `shot_ready` rises exactly 65 cycles after the pulse; `hits_remaining` = 3, `turns_left` = 40.
- Shot (0,0) then (0,0): first result `hit` = 1; second result `repeat_shot` = 1, `turns_left` stays 39; each `result_valid` arrives 2 cycles after acceptance.
- Shot (1,1), (7,7), (0,0) with MAX_TURNS = 40: the third result sets `all_ships_sunk` = 1, state OVER, `shot_ready` = 0.
- MAX_TURNS = 2 and two misses: `turns_exhausted` = 1 with the second result. A third `shot_valid` is never accepted.
- `restart_pulse` in the EVAL cycle: no `result_valid`; the board is reloaded, and `hits_remaining` and `turns_left` are restored.
- Layout all zeros: after the scan, `all_ships_sunk` = 1 and the state is OVER without ever reaching READY. Also cover ROWS = 6 with row 7: `invalid_shot` = 1 and `turns_left` unchanged.
